// File: rtl/qupls4_queue_arbiter.sv
// Round-robin arbiter sharing the 16-queue bank among NREQ requesters: issues one-hot
// queue strobes and returns fixed-latency read data and tag to the issuing requester.
module qupls4_queue_arbiter #(
   parameter int NREQ   = 4,
   parameter int RD_LAT = 3,
   parameter int TAGW   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_cmd,
   input  logic [4*NREQ-1:0]    req_qid,
   input  logic [16*NREQ-1:0]   req_addr,
   input  logic [64*NREQ-1:0]   req_data,
   input  logic [TAGW*NREQ-1:0] req_tag,
   output logic [15:0]          q_rst,
   output logic [15:0]          q_rd,
   output logic [15:0]          q_wr,
   output logic [15:0]          q_addr,
   output logic [63:0]          q_wr_data,
   input  logic [63:0]          q_rd_data [16],
   output logic [NREQ-1:0]      rsp_valid,
   output logic [63:0]          rsp_data,
   output logic [TAGW-1:0]      rsp_tag,
   output logic [NREQ-1:0]      done_valid,
   output logic [TAGW-1:0]      done_tag
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {
      CMD_NOP = 2'b00,
      CMD_RST = 2'b01,
      CMD_RD  = 2'b10,
      CMD_WR  = 2'b11
   } cmd_e;

   typedef struct packed {
      logic            valid;
      logic [PW-1:0]   req;
      logic [3:0]      qid;
      logic [TAGW-1:0] tag;
   } ret_t;

   logic [PW-1:0]   r_rr_ptr;
   logic [15:0]     r_q_rst;
   logic [15:0]     r_q_rd;
   logic [15:0]     r_q_wr;
   logic [15:0]     r_q_addr;
   logic [63:0]     r_q_wr_data;
   logic [NREQ-1:0] r_done_valid;
   logic [TAGW-1:0] r_done_tag;
   logic [63:0]     r_rsp_data;
   ret_t            r_pipe [RD_LAT];
   ret_t            r_ret;

   logic [15:0]     w_busy_q;
   logic [NREQ-1:0] w_elig;
   logic            w_gnt_any;
   logic [PW-1:0]   w_gnt_idx;
   cmd_e            w_g_cmd;
   logic [3:0]      w_g_qid;
   logic [15:0]     w_g_addr;
   logic [63:0]     w_g_data;
   logic [TAGW-1:0] w_g_tag;

   // Queues with a read still in the pipe or on the response port; resets to them must wait.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_busy_q = '0;
      for (int s = 0; s < RD_LAT; s++)
         if (r_pipe[s].valid) w_busy_q[r_pipe[s].qid] = 1'b1;
      if (r_ret.valid) w_busy_q[r_ret.qid] = 1'b1;
   end

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NREQ; i++)
         w_elig[i] = req_valid[i] &&
                     !((cmd_e'(req_cmd[2*i +: 2]) == CMD_RST) && w_busy_q[req_qid[4*i +: 4]]);
   end

   always_comb begin : grant_comb
      int v_idx;
      v_idx     = 0;
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         v_idx = int'(r_rr_ptr) + k;
         if (v_idx >= NREQ) v_idx = v_idx - NREQ;
         if (!w_gnt_any && w_elig[PW'(v_idx)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = PW'(v_idx);
         end
      end
      if (flush || rst) w_gnt_any = 1'b0;
      if (w_gnt_any) req_ready[w_gnt_idx] = 1'b1;
   end

   always_comb begin
      w_g_cmd  = CMD_NOP;
      w_g_qid  = '0;
      w_g_addr = '0;
      w_g_data = '0;
      w_g_tag  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_idx == PW'(i)) begin
            w_g_cmd  = cmd_e'(req_cmd[2*i +: 2]);
            w_g_qid  = req_qid[4*i +: 4];
            w_g_addr = req_addr[16*i +: 16];
            w_g_data = req_data[64*i +: 64];
            w_g_tag  = req_tag[TAGW*i +: TAGW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr     <= '0;
         r_q_rst      <= '0;
         r_q_rd       <= '0;
         r_q_wr       <= '0;
         r_q_addr     <= '0;
         r_q_wr_data  <= '0;
         r_done_valid <= '0;
         r_done_tag   <= '0;
         r_rsp_data   <= '0;
         r_ret        <= '0;
         // NOTE: the return pipe is reset because its valid bits gate responses and hazards.
         for (int s = 0; s < RD_LAT; s++) r_pipe[s] <= '0;
      end else begin
         r_q_rst      <= '0;
         r_q_rd       <= '0;
         r_q_wr       <= '0;
         r_done_valid <= '0;
         r_pipe[0]    <= '0;
         for (int s = 1; s < RD_LAT; s++)
            r_pipe[s] <= flush ? '0 : r_pipe[s-1];
         r_ret <= flush ? '0 : r_pipe[RD_LAT-1];
         if (r_pipe[RD_LAT-1].valid && !flush)
            r_rsp_data <= q_rd_data[r_pipe[RD_LAT-1].qid];

         if (w_gnt_any) begin
            r_rr_ptr    <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + PW'(1);
            r_q_addr    <= w_g_addr;
            r_q_wr_data <= w_g_data;
            case (w_g_cmd)
               CMD_RD: begin
                  r_q_rd[w_g_qid] <= 1'b1;
                  r_pipe[0] <= '{valid: 1'b1, req: w_gnt_idx, qid: w_g_qid, tag: w_g_tag};
               end
               CMD_RST: begin
                  r_q_rst[w_g_qid]        <= 1'b1;
                  r_done_valid[w_gnt_idx] <= 1'b1;
                  r_done_tag              <= w_g_tag;
               end
               CMD_WR: begin
                  r_q_wr[w_g_qid]         <= 1'b1;
                  r_done_valid[w_gnt_idx] <= 1'b1;
                  r_done_tag              <= w_g_tag;
               end
               CMD_NOP: begin
                  r_done_valid[w_gnt_idx] <= 1'b1;
                  r_done_tag              <= w_g_tag;
               end
            endcase
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (r_ret.valid) rsp_valid[r_ret.req] = 1'b1;
   end

   assign rsp_tag    = r_ret.tag;
   assign rsp_data   = r_rsp_data;
   assign q_rst      = r_q_rst;
   assign q_rd       = r_q_rd;
   assign q_wr       = r_q_wr;
   assign q_addr     = r_q_addr;
   assign q_wr_data  = r_q_wr_data;
   assign done_valid = r_done_valid;
   assign done_tag   = r_done_tag;

endmodule

// File: tb/tb_qupls4_queue_arbiter.sv
// Directed bench for qupls4_queue_arbiter: reset, single read, round-robin writes,
// reset hazard, back-to-back reads, flush and mid-operation reset.
module tb_qupls4_queue_arbiter;

   localparam int NREQ = 4;
   localparam int TAGW = 8;
   localparam logic [1:0] C_NOP = 2'b00, C_RST = 2'b01, C_RD = 2'b10, C_WR = 2'b11;

   logic                 clk;
   logic                 rst;
   logic                 flush;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [2*NREQ-1:0]    req_cmd;
   logic [4*NREQ-1:0]    req_qid;
   logic [16*NREQ-1:0]   req_addr;
   logic [64*NREQ-1:0]   req_data;
   logic [TAGW*NREQ-1:0] req_tag;
   logic [15:0]          q_rst, q_rd, q_wr, q_addr;
   logic [63:0]          q_wr_data;
   logic [63:0]          q_rd_data [16];
   logic [NREQ-1:0]      rsp_valid;
   logic [63:0]          rsp_data;
   logic [TAGW-1:0]      rsp_tag;
   logic [NREQ-1:0]      done_valid;
   logic [TAGW-1:0]      done_tag;

   int n_checks = 0;
   int n_errors = 0;

   qupls4_queue_arbiter #(.NREQ(NREQ), .RD_LAT(3), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_qid(req_qid), .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
      .q_rst(q_rst), .q_rd(q_rd), .q_wr(q_wr), .q_addr(q_addr), .q_wr_data(q_wr_data),
      .q_rd_data(q_rd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .done_valid(done_valid), .done_tag(done_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] cmd, input logic [3:0] qid,
                          input logic [15:0] addr, input logic [63:0] data, input logic [7:0] tag);
      req_valid[i]          = 1'b1;
      req_cmd[2*i +: 2]     = cmd;
      req_qid[4*i +: 4]     = qid;
      req_addr[16*i +: 16]  = addr;
      req_data[64*i +: 64]  = data;
      req_tag[TAGW*i +: TAGW] = tag;
   endtask

   task automatic clr_req(input int i);
      req_valid[i] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0;
      req_valid = '0; req_cmd = '0; req_qid = '0; req_addr = '0; req_data = '0; req_tag = '0;
      for (int i = 0; i < 16; i++) q_rd_data[i] = 64'hCAFE_0000_0000_0000 + 64'(i) * 64'h0101;

      // Reset state, with a valid request that must not be granted under reset
      tick(); tick();
      set_req(0, C_RD, 4'd5, 16'h0010, 64'h0, 8'h21);
      #1;
      check("rst_ready", req_ready, 4'b0000);
      check("rst_q_rst", q_rst, 16'h0);
      check("rst_q_rd", q_rd, 16'h0);
      check("rst_q_wr", q_wr, 16'h0);
      check("rst_q_addr", q_addr, 16'h0);
      check("rst_q_wr_data", q_wr_data, 64'h0);
      check("rst_rsp_valid", rsp_valid, 4'b0);
      check("rst_rsp_tag", rsp_tag, 8'h0);
      check("rst_done_valid", done_valid, 4'b0);
      check("rst_done_tag", done_tag, 8'h0);

      // Single read: req0 q5 addr 0x10 tag 0x21
      rst = 1'b0;
      #1;
      check("rd1_ready_t0", req_ready, 4'b0001);
      tick(); clr_req(0);
      check("rd1_q_rd_t1", q_rd, 16'h0020);
      check("rd1_q_addr_t1", q_addr, 16'h0010);
      check("rd1_q_wr_t1", q_wr, 16'h0);
      check("rd1_done_t1", done_valid, 4'b0);
      tick();
      check("rd1_q_rd_t2", q_rd, 16'h0);
      tick();
      check("rd1_rsp_t3", rsp_valid, 4'b0);
      tick();
      check("rd1_rsp_t4", rsp_valid, 4'b0001);
      check("rd1_tag_t4", rsp_tag, 8'h21);
      check("rd1_data_t4", rsp_data, 64'hCAFE_0000_0000_0505);
      tick();
      check("rd1_rsp_t5", rsp_valid, 4'b0);

      // Round-robin writes from all four requesters
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_req(i, C_WR, 4'(4 + i), 16'(16'h0100 + i), 64'(64'h1000 + i), 8'(8'h30 + i));
      for (int k = 0; k < 5; k++) begin
         int g;
         g = k % NREQ;
         #1;
         check("rr_ready", req_ready, 64'(1) << g);
         tick();
         check("rr_q_wr", q_wr, 64'(1) << (4 + g));
         check("rr_done", done_valid, 64'(1) << g);
         check("rr_done_tag", done_tag, 64'(8'h30 + g));
         check("rr_wdata", q_wr_data, 64'(64'h1000 + g));
      end
      req_valid = '0;
      tick();
      check("rr_idle_q_wr", q_wr, 16'h0);
      check("rr_idle_done", done_valid, 4'b0);

      // Reset hazard on queue 14; unrelated reset to queue 3 proceeds meanwhile
      do_reset();
      set_req(0, C_RD, 4'd14, 16'h0E00, 64'h0, 8'h41);
      #1;
      check("hz_ready_t0", req_ready, 4'b0001);
      tick(); clr_req(0);
      set_req(1, C_RST, 4'd14, 16'h0000, 64'h0, 8'h52);
      #1;
      check("hz_ready_t1", req_ready, 4'b0000);
      check("hz_q_rd_t1", q_rd, 16'h4000);
      tick();
      set_req(2, C_RST, 4'd3, 16'h0003, 64'h0, 8'h63);
      #1;
      check("hz_ready_t2", req_ready, 4'b0100);
      tick(); clr_req(2);
      #1;
      check("hz_q_rst_t3", q_rst, 16'h0008);
      check("hz_done_t3", done_valid, 4'b0100);
      check("hz_ready_t3", req_ready, 4'b0000);
      tick();
      check("hz_rsp_t4", rsp_valid, 4'b0001);
      check("hz_tag_t4", rsp_tag, 8'h41);
      check("hz_data_t4", rsp_data, 64'hCAFE_0000_0000_0E0E);
      check("hz_ready_t4", req_ready, 4'b0000);
      tick();
      check("hz_ready_t5", req_ready, 4'b0010);
      check("hz_rsp_t5", rsp_valid, 4'b0);
      tick(); clr_req(1);
      check("hz_q_rst_t6", q_rst, 16'h4000);
      check("hz_done_t6", done_valid, 4'b0010);
      check("hz_done_tag_t6", done_tag, 8'h52);

      // Back-to-back reads to queues 1, 2, 3 from requesters 0, 1, 2
      do_reset();
      set_req(0, C_RD, 4'd1, 16'h0001, 64'h0, 8'h71);
      #1;
      check("b2b_ready_t0", req_ready, 4'b0001);
      tick(); clr_req(0);
      set_req(1, C_RD, 4'd2, 16'h0002, 64'h0, 8'h72);
      #1;
      check("b2b_ready_t1", req_ready, 4'b0010);
      check("b2b_q_rd_t1", q_rd, 16'h0002);
      tick(); clr_req(1);
      set_req(2, C_RD, 4'd3, 16'h0003, 64'h0, 8'h73);
      #1;
      check("b2b_ready_t2", req_ready, 4'b0100);
      check("b2b_q_rd_t2", q_rd, 16'h0004);
      tick(); clr_req(2);
      check("b2b_q_rd_t3", q_rd, 16'h0008);
      check("b2b_rsp_t3", rsp_valid, 4'b0);
      tick();
      check("b2b_rsp_t4", rsp_valid, 4'b0001);
      check("b2b_tag_t4", rsp_tag, 8'h71);
      check("b2b_data_t4", rsp_data, 64'hCAFE_0000_0000_0101);
      tick();
      check("b2b_rsp_t5", rsp_valid, 4'b0010);
      check("b2b_tag_t5", rsp_tag, 8'h72);
      check("b2b_data_t5", rsp_data, 64'hCAFE_0000_0000_0202);
      tick();
      check("b2b_rsp_t6", rsp_valid, 4'b0100);
      check("b2b_tag_t6", rsp_tag, 8'h73);
      check("b2b_data_t6", rsp_data, 64'hCAFE_0000_0000_0303);
      tick();
      check("b2b_rsp_t7", rsp_valid, 4'b0);

      // Flush kills two in-flight reads and blocks the grant in its cycle
      do_reset();
      set_req(0, C_RD, 4'd6, 16'h0006, 64'h0, 8'h81);
      #1;
      check("fl_ready_t0", req_ready, 4'b0001);
      tick(); clr_req(0);
      set_req(1, C_RD, 4'd7, 16'h0007, 64'h0, 8'h82);
      #1;
      check("fl_ready_t1", req_ready, 4'b0010);
      tick(); clr_req(1);
      flush = 1'b1;
      set_req(2, C_WR, 4'd8, 16'h0008, 64'h8888, 8'h83);
      #1;
      check("fl_ready_t2", req_ready, 4'b0000);
      check("fl_q_rd_t2", q_rd, 16'h0080);
      tick();
      flush = 1'b0;
      req_valid = '0;
      check("fl_q_wr_t3", q_wr, 16'h0);
      check("fl_rsp_t3", rsp_valid, 4'b0);
      tick();
      check("fl_rsp_t4", rsp_valid, 4'b0);
      tick();
      check("fl_rsp_t5", rsp_valid, 4'b0);

      // Reset with two reads in flight
      do_reset();
      set_req(0, C_RD, 4'd9, 16'h0909, 64'h0, 8'h91);
      #1;
      check("mr_ready_t0", req_ready, 4'b0001);
      tick(); clr_req(0);
      set_req(1, C_RD, 4'd10, 16'h0A0A, 64'h0, 8'h92);
      #1;
      check("mr_ready_t1", req_ready, 4'b0010);
      check("mr_q_rd_t1", q_rd, 16'h0200);
      tick(); clr_req(1);
      rst = 1'b1;
      set_req(3, C_WR, 4'd11, 16'h0B0B, 64'hBBBB, 8'hB3);
      #1;
      check("mr_ready_t2", req_ready, 4'b0000);
      tick();
      rst = 1'b0;
      set_req(1, C_WR, 4'd12, 16'h0C0C, 64'hCCCC, 8'hA1);
      #1;
      check("mr_q_rd_t3", q_rd, 16'h0);
      check("mr_q_wr_t3", q_wr, 16'h0);
      check("mr_q_rst_t3", q_rst, 16'h0);
      check("mr_q_addr_t3", q_addr, 16'h0);
      check("mr_q_wr_data_t3", q_wr_data, 64'h0);
      check("mr_rsp_t3", rsp_valid, 4'b0);
      check("mr_rsp_tag_t3", rsp_tag, 8'h0);
      check("mr_done_t3", done_valid, 4'b0);
      check("mr_ready_t3", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      check("mr_q_wr_t4", q_wr, 16'h1000);
      check("mr_done_t4", done_valid, 4'b0010);
      check("mr_rsp_t4", rsp_valid, 4'b0);
      tick();
      check("mr_rsp_t5", rsp_valid, 4'b0);
      tick();
      check("mr_rsp_t6", rsp_valid, 4'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
